// File: rtl/miriscv_lsu.sv
// Load-store unit: turns core load/store requests into word-aligned bus accesses and
// extends returned load data. Define MIRISCV_LSU_MISALIGN_TRAP_EN to flag misaligned H/W.
module miriscv_lsu (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [2:0]  lsu_size_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_data_i,
    output logic [31:0] lsu_data_o,
    output logic        lsu_stall_req_o,
    output logic        lsu_misalign_o,

    input  logic [31:0] data_rdata_i,
    output logic        data_req_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o
);

    typedef enum logic {
        StIdle,
        StWait
    } state_e;

    state_e      r_state;
    state_e      w_state_next;
    logic [2:0]  r_size;
    logic [1:0]  r_off;
    logic        r_we;

    logic        w_misalign;
    logic        w_start;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;

`ifdef MIRISCV_LSU_MISALIGN_TRAP_EN
    assign w_misalign = ((lsu_size_i[1:0] == 2'b01) && lsu_addr_i[0])
                     || ((lsu_size_i == 3'b010) && (lsu_addr_i[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_start = (r_state == StIdle) && lsu_req_i && !w_misalign && !rst_i;

    // size[2] only selects sign/zero extension, so lane decode looks at size[1:0] alone
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = lsu_data_i;
        case (lsu_size_i[1:0])
            2'b00: begin
                w_be    = 4'b0001 << lsu_addr_i[1:0];
                w_wdata = {4{lsu_data_i[7:0]}};
            end
            2'b01: begin
                w_be    = lsu_addr_i[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{lsu_data_i[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = lsu_data_i;
            end
        endcase
    end

    always_comb begin
        w_byte = data_rdata_i[7:0];
        case (r_off)
            2'b00:   w_byte = data_rdata_i[7:0];
            2'b01:   w_byte = data_rdata_i[15:8];
            2'b10:   w_byte = data_rdata_i[23:16];
            default: w_byte = data_rdata_i[31:24];
        endcase
        w_half = r_off[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];
    end

    always_comb begin
        w_load = data_rdata_i;
        case (r_size)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load = {24'h0, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b101:  w_load = {16'h0, w_half};
            default: w_load = data_rdata_i;
        endcase
    end

    always_comb begin
        w_state_next    = r_state;
        data_req_o      = 1'b0;
        data_we_o       = 1'b0;
        data_be_o       = 4'b0000;
        data_addr_o     = 32'h0;
        data_wdata_o    = 32'h0;
        lsu_stall_req_o = 1'b0;
        lsu_misalign_o  = 1'b0;
        lsu_data_o      = 32'h0;

        case (r_state)
            StIdle: begin
                if (lsu_req_i) begin
                    if (w_misalign) begin
                        lsu_misalign_o = 1'b1;
                    end else begin
                        data_req_o      = 1'b1;
                        lsu_stall_req_o = 1'b1;
                        data_we_o       = lsu_we_i;
                        data_be_o       = w_be;
                        data_addr_o     = {lsu_addr_i[31:2], 2'b00};
                        data_wdata_o    = w_wdata;
                        w_state_next    = StWait;
                    end
                end
            end
            StWait: begin
                // The core still presents the same instruction here; its request is not re-taken.
                w_state_next = StIdle;
                if (!r_we) begin
                    lsu_data_o = w_load;
                end
            end
            default: w_state_next = StIdle;
        endcase

        if (rst_i) begin
            w_state_next    = StIdle;
            data_req_o      = 1'b0;
            data_we_o       = 1'b0;
            data_be_o       = 4'b0000;
            data_addr_o     = 32'h0;
            data_wdata_o    = 32'h0;
            lsu_stall_req_o = 1'b0;
            lsu_misalign_o  = 1'b0;
            lsu_data_o      = 32'h0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= StIdle;
            r_size  <= 3'b000;
            r_off   <= 2'b00;
            r_we    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_start) begin
                r_size <= lsu_size_i;
                r_off  <= lsu_addr_i[1:0];
                r_we   <= lsu_we_i;
            end
        end
    end

endmodule
